// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl
//   Compacts the board after a piece has been saved. Rows are scanned bottom
//   up. Full rows are dropped, the kept rows above them are copied down, and
//   the vacated top rows are blanked. The shared RAM port is only driven while
//   the external access window (grant) is open.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle request for a pass (ignored unless idle)
//   grant           : RAM port owned by this block while high
//   rd_data         : row read data, column i at [DW*i +: DW]
//   ram_row         : row address for every column RAM (registered)
//   wr_data         : row write data, same packing as rd_data
//   we              : per-column write enable
//   busy            : pass in progress (cycle after start .. DONE cycle)
//   done            : one-cycle pulse at the end of a pass
//   lines_cleared   : full rows removed by the last pass
//   total_lines     : running sum of lines_cleared, saturating at 1023
module line_clear_ctrl #(
    parameter int ROWS = 20,
    parameter int COLS = 10,
    parameter int DW   = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 grant,
    input  logic [COLS*DW-1:0]   rd_data,
    output logic [4:0]           ram_row,
    output logic [COLS*DW-1:0]   wr_data,
    output logic [COLS-1:0]      we,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines_cleared,
    output logic [9:0]           total_lines
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_EVAL,
        S_WRITE,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t               state_q;
    logic [4:0]           rd_q;
    logic [4:0]           wr_q;
    logic [5:0]           count_q;
    logic [4:0]           ram_row_q;
    logic [COLS*DW-1:0]   wr_data_q;
    logic                 busy_q;
    logic                 done_q;
    logic [4:0]           lines_q;
    logic [9:0]           total_q;

    // Pointers stop at row 0 instead of wrapping.
    function automatic logic [4:0] dec_ptr(input logic [4:0] p);
        return (p == 5'd0) ? 5'd0 : p - 5'd1;
    endfunction

    function automatic logic [9:0] add_sat_total(input logic [9:0] t, input logic [5:0] n);
        logic [10:0] s;
        s = {1'b0, t} + {5'd0, n};
        return s[10] ? 10'h3FF : s[9:0];
    endfunction

    function automatic logic [4:0] sat_lines(input logic [5:0] n);
        return n[5] ? 5'h1F : n[4:0];
    endfunction

    logic       row_full;
    logic [5:0] eval_cnt;
    logic [4:0] eval_wr;
    logic       eval_write;
    logic [5:0] adv_cnt;
    logic [4:0] adv_wr;
    state_t     adv_state;
    logic       adv_fire;
    logic       enter_done;

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (rd_data[c*DW +: DW] == '0) row_full = 1'b0;
        end

        eval_cnt   = count_q + {5'd0, row_full};
        eval_write = !row_full && (wr_q != rd_q);
        // A kept row already sitting at its destination needs no copy.
        eval_wr    = (!row_full && (wr_q == rd_q)) ? dec_ptr(wr_q) : wr_q;

        // Row advance shared by EVAL (no copy needed) and a completed WRITE.
        adv_cnt   = (state_q == S_EVAL) ? eval_cnt : count_q;
        adv_wr    = (state_q == S_EVAL) ? eval_wr  : dec_ptr(wr_q);
        if (rd_q != 5'd0)       adv_state = S_ADDR;
        else if (adv_cnt == '0) adv_state = S_DONE;
        else                    adv_state = S_FILL;

        adv_fire   = grant && (((state_q == S_EVAL) && !eval_write) || (state_q == S_WRITE));
        enter_done = (adv_fire && (adv_state == S_DONE)) ||
                     ((state_q == S_FILL) && grant && (wr_q == 5'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_q      <= LAST_ROW;
            wr_q      <= LAST_ROW;
            count_q   <= '0;
            ram_row_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lines_q   <= '0;
            total_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ADDR;
                        rd_q    <= LAST_ROW;
                        wr_q    <= LAST_ROW;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (grant) begin
                        ram_row_q <= rd_q;
                        state_q   <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    // Losing the window here means rd_data is not ours: re-read.
                    if (!grant) begin
                        state_q <= S_ADDR;
                    end else begin
                        count_q <= eval_cnt;
                        if (eval_write) begin
                            wr_data_q <= rd_data;
                            ram_row_q <= wr_q;
                            state_q   <= S_WRITE;
                        end
                    end
                end
                S_WRITE: ;
                S_FILL: begin
                    if (grant && (wr_q != 5'd0)) begin
                        wr_q      <= dec_ptr(wr_q);
                        ram_row_q <= dec_ptr(wr_q);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (adv_fire) begin
                state_q <= adv_state;
                rd_q    <= dec_ptr(rd_q);
                wr_q    <= adv_wr;
                if (adv_state == S_FILL) begin
                    ram_row_q <= adv_wr;
                    wr_data_q <= '0;
                end
            end

            if (enter_done) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                lines_q <= sat_lines(adv_cnt);
                total_q <= add_sat_total(total_q, adv_cnt);
            end
        end
    end

    // Write enable is gated by the live grant so the port is never written
    // in a cycle that belongs to the video readout.
    assign we = (grant && ((state_q == S_WRITE) || (state_q == S_FILL))) ? '1 : '0;

    assign ram_row       = ram_row_q;
    assign wr_data       = wr_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
module tb_line_clear_ctrl;
    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int DW   = 24;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                grant;
    logic [COLS*DW-1:0]  rd_data;
    logic [4:0]          ram_row;
    logic [COLS*DW-1:0]  wr_data;
    logic [COLS-1:0]     we;
    logic                busy;
    logic                done;
    logic [4:0]          lines_cleared;
    logic [9:0]          total_lines;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .grant(grant), .rd_data(rd_data),
        .ram_row(ram_row), .wr_data(wr_data), .we(we), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .total_lines(total_lines)
    );

    // Column RAMs: asynchronous read of the registered address, junk while
    // the port belongs to video, synchronous write.
    logic [DW-1:0] board  [ROWS][COLS];
    logic [DW-1:0] init_b [ROWS][COLS];
    logic [DW-1:0] exp_b  [ROWS][COLS];
    logic [DW-1:0] junk = 24'h5A5A5A;
    logic          load_req = 1'b0;

    always @(posedge clk) begin
        junk <= DW'($urandom | 32'd1);
        if (load_req) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) board[r][c] <= init_b[r][c];
        end else if (we != '0 && int'(ram_row) < ROWS) begin
            for (int c = 0; c < COLS; c++)
                if (we[c]) board[ram_row][c] <= wr_data[c*DW +: DW];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < COLS; c++)
            rd_data[c*DW +: DW] = (grant && int'(ram_row) < ROWS) ? board[ram_row][c] : junk;
    end

    // Grant generator: 0 = always open, 1 = 3 open / 5 closed, 2 = random.
    int gmode_v = 0;
    int gph     = 0;
    initial begin
        grant = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (gmode_v)
                1: begin gph = (gph + 1) % 8; grant = (gph < 3); end
                2: grant = ($urandom_range(0, 3) != 0);
                default: grant = 1'b1;
            endcase
        end
    end

    // ---------------- reference model ----------------
    int exp_lines = 0;
    int exp_w     = 0;
    int exp_total = 0;

    function automatic bit full_row(input int r);
        for (int c = 0; c < COLS; c++) if (board[r][c] == '0) return 1'b0;
        return 1'b1;
    endfunction

    // Final board = kept rows stacked at the bottom in original order, zeros above.
    task automatic model_pass();
        int k;
        int lowest;
        k = ROWS - 1;
        lowest = -1;
        exp_lines = 0;
        exp_w = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (full_row(r)) begin
                exp_lines++;
                if (lowest < 0) lowest = r;
            end else begin
                for (int c = 0; c < COLS; c++) exp_b[k][c] = board[r][c];
                k--;
            end
        end
        for (int r = k; r >= 0; r--)
            for (int c = 0; c < COLS; c++) exp_b[r][c] = '0;
        for (int r = 0; r < lowest; r++) if (!full_row(r)) exp_w++;
        exp_total = (exp_total + exp_lines > 1023) ? 1023 : exp_total + exp_lines;
    endtask

    function automatic int board_diff();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) if (board[r][c] != exp_b[r][c]) n++;
        return n;
    endfunction

    function automatic int row_vs_init(input int r, input int s);
        int n = 0;
        for (int c = 0; c < COLS; c++) if (board[r][c] != init_b[s][c]) n++;
        return n;
    endfunction

    function automatic int row_nonzero(input int r);
        int n = 0;
        for (int c = 0; c < COLS; c++) if (board[r][c] != '0) n++;
        return n;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // kind: 0 empty, 1 full, 2 partial (at least one empty cell)
    task automatic set_row(input int r, input int kind);
        logic [DW-1:0] v;
        for (int c = 0; c < COLS; c++) begin
            v = DW'($urandom | 32'd1);
            case (kind)
                0: init_b[r][c] = '0;
                1: init_b[r][c] = v;
                default: init_b[r][c] = ($urandom_range(0, 2) == 0) ? '0 : v;
            endcase
        end
        if (kind == 2) init_b[r][$urandom_range(0, COLS - 1)] = '0;
    endtask

    task automatic load_board();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Runs one pass, checking every cycle and then the final outcome.
    task automatic run_pass(input int gmode, input int want_lat, input bit mid_start, output int nwe);
        int n;
        int lat;
        int ndone;
        model_pass();
        gmode_v = gmode;
        n = 0; lat = -1; ndone = 0; nwe = 0;
        @(negedge clk);
        start = 1'b1;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (mid_start && n == 15) start = 1'b1;
            if (mid_start && n == 16) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            if (we != '0) nwe++;
            if (!grant || !busy) check("we_outside_window", int'(we), 0);
            check("busy_during_pass", int'(busy), (lat < 0 || n == lat) ? 1 : 0);
            if (lat >= 0 && n >= lat + 4) break;
        end
        if (lat < 0) check("done_timeout", 0, 1);
        check("done_pulses", ndone, 1);
        if (gmode == 0) check("latency_model", lat, 1 + 2 * ROWS + exp_w + exp_lines);
        if (want_lat > 0) check("latency_literal", lat, want_lat);
        check("write_cycles", nwe, exp_w + exp_lines);
        check("lines_cleared", int'(lines_cleared), exp_lines);
        check("total_lines", int'(total_lines), exp_total);
        check("board_mismatch_cells", board_diff(), 0);
    endtask

    initial begin
        int nwe;
        int found;
        rst = 1'b1;
        start = 1'b0;
        for (int r = 0; r < ROWS; r++) set_row(r, 0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ram_row", int'(ram_row), 0);
        check("rst_wr_data", int'(wr_data != '0), 0);
        check("rst_we", int'(we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_lines", int'(lines_cleared), 0);
        check("rst_total", int'(total_lines), 0);
        rst = 1'b0;
        load_board();

        // Empty board
        run_pass(0, 41, 1'b0, nwe);
        check("empty_we_count", nwe, 0);
        check("empty_lines", int'(lines_cleared), 0);
        check("empty_total", int'(total_lines), 0);

        // Row 19 full, others partial
        for (int r = 0; r < ROWS - 1; r++) set_row(r, 2);
        set_row(ROWS - 1, 1);
        load_board();
        run_pass(0, 61, 1'b0, nwe);
        check("r19_we_count", nwe, 20);
        check("r19_lines", int'(lines_cleared), 1);
        check("r19_row19_from_18", row_vs_init(19, 18), 0);
        check("r19_row1_from_0", row_vs_init(1, 0), 0);
        check("r19_row0_zero", row_nonzero(0), 0);

        // Rows 16..19 full, row 15 = fixed pattern; fresh total
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_total = 0;
        for (int r = 0; r < 15; r++) set_row(r, 2);
        for (int c = 0; c < COLS; c++) init_b[15][c] = (c == COLS - 1) ? '0 : DW'(c * 4097 + 5);
        for (int r = 16; r < ROWS; r++) set_row(r, 1);
        load_board();
        run_pass(0, 61, 1'b0, nwe);
        check("four_p_in_row19", row_vs_init(19, 15), 0);
        check("four_row0_zero", row_nonzero(0), 0);
        check("four_row3_zero", row_nonzero(3), 0);
        check("four_lines", int'(lines_cleared), 4);
        check("four_total", int'(total_lines), 4);
        run_pass(0, 41, 1'b0, nwe);
        check("four_again_lines", int'(lines_cleared), 0);
        check("four_again_total", int'(total_lines), 4);

        // Rows 19 and 17 full
        for (int r = 0; r < ROWS; r++) set_row(r, (r == 19 || r == 17) ? 1 : 2);
        load_board();
        run_pass(0, 61, 1'b0, nwe);
        check("gap_row19_from_18", row_vs_init(19, 18), 0);
        check("gap_row18_from_16", row_vs_init(18, 16), 0);
        check("gap_row2_from_0", row_vs_init(2, 0), 0);
        check("gap_row1_zero", row_nonzero(1), 0);
        check("gap_lines", int'(lines_cleared), 2);

        // Row 19 full with grant 3 on / 5 off
        for (int r = 0; r < ROWS - 1; r++) set_row(r, 2);
        set_row(ROWS - 1, 1);
        load_board();
        run_pass(1, 0, 1'b0, nwe);
        check("toggle_row19_from_18", row_vs_init(19, 18), 0);

        // start pulsed mid-pass
        for (int r = 0; r < ROWS; r++) set_row(r, ($urandom_range(0, 3) == 0) ? 1 : 2);
        load_board();
        run_pass(0, 0, 1'b1, nwe);

        // Random boards, random grant
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < ROWS; r++) set_row(r, ($urandom_range(0, 2) == 0) ? 1 : 2);
            load_board();
            run_pass(2, 0, 1'b0, nwe);
        end

        // All rows full, repeated until total saturates
        for (int i = 0; i < 52; i++) begin
            for (int r = 0; r < ROWS; r++) set_row(r, 1);
            load_board();
            run_pass(0, 61, 1'b0, nwe);
        end
        check("sat_total_literal", int'(total_lines), 1023);
        check("full_lines_literal", int'(lines_cleared), 20);

        // Reset in the middle of a WRITE
        for (int r = 0; r < ROWS - 1; r++) set_row(r, 2);
        set_row(ROWS - 1, 1);
        load_board();
        gmode_v = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (we != '0) found = 1;
        end
        check("reached_write", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_we", int'(we), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_total", int'(total_lines), 0);
        rst = 1'b0;
        exp_total = 0;
        for (int r = 0; r < ROWS; r++) set_row(r, 0);
        load_board();
        run_pass(0, 41, 1'b0, nwe);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
